// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// One op in flight: IDLE accepts, EXEC runs the ALU, RESP holds the result.
module alu_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic [2:0]  req0_select_i,
  input  logic        req0_rotate_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  input  logic [2:0]  req1_select_i,
  input  logic        req1_rotate_i,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_select_o,
  output logic        alu_rotate_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  input  logic        alu_sign_i,
  input  logic        alu_sltu_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_id_o,
  output logic [31:0] resp_result_o,
  output logic        resp_zero_o,
  output logic        resp_sign_o,
  output logic        resp_sltu_o
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  sel_q;
  logic        rot_q;
  logic        id_q;
  logic        rvalid_q;
  logic        rid_q;
  logic [31:0] rres_q;
  logic        rzero_q, rsign_q, rsltu_q;

  logic        idle;
  logic        both;
  logic        gnt0, gnt1;
  logic        acc;
  logic        id_d;
  logic [31:0] a_d, b_d;
  logic [2:0]  sel_d;
  logic        rot_d;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    idle  = (state_q == IDLE) && !rst_i;
    both  = req0_valid_i && req1_valid_i;
    gnt0  = both ? last_q : req0_valid_i;
    gnt1  = both ? ~last_q : req1_valid_i;
    req0_ready_o = idle && gnt0;
    req1_ready_o = idle && gnt1;
    acc   = (req0_valid_i && req0_ready_o) ||
            (req1_valid_i && req1_ready_o);
    id_d  = req1_ready_o;
    a_d   = id_d ? req1_data1_i  : req0_data1_i;
    b_d   = id_d ? req1_data2_i  : req0_data2_i;
    sel_d = id_d ? req1_select_i : req0_select_i;
    rot_d = id_d ? req1_rotate_i : req0_rotate_i;
  end

  // Sequencer: latch op on accept, capture ALU after EXEC, hold until taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= ~PRIO_INIT;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      rot_q    <= 1'b0;
      id_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      rres_q   <= '0;
      rzero_q  <= 1'b0;
      rsign_q  <= 1'b0;
      rsltu_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            rot_q   <= rot_d;
            id_q    <= id_d;
            last_q  <= id_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rres_q   <= alu_result_i;
          rzero_q  <= alu_zero_i;
          rsign_q  <= alu_sign_i;
          rsltu_q  <= alu_sltu_i;
          rid_q    <= id_q;
          rvalid_q <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_data1_o   = a_q;
  assign alu_data2_o   = b_q;
  assign alu_select_o  = sel_q;
  assign alu_rotate_o  = rot_q;
  assign resp_valid_o  = rvalid_q;
  assign resp_id_o     = rid_q;
  assign resp_result_o = rres_q;
  assign resp_zero_o   = rzero_q;
  assign resp_sign_o   = rsign_q;
  assign resp_sltu_o   = rsltu_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a
// randomized run against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, r0, v1, r1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  s0, s1;
  logic        o0, o1;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_s;
  logic        alu_r, alu_z, alu_sg, alu_lt;
  logic        rv, rr, rid;
  logic [31:0] rres;
  logic        rz, rsg, rlt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0),
    .req0_data1_i(a0), .req0_data2_i(b0),
    .req0_select_i(s0), .req0_rotate_i(o0),
    .req1_valid_i(v1), .req1_ready_o(r1),
    .req1_data1_i(a1), .req1_data2_i(b1),
    .req1_select_i(s1), .req1_rotate_i(o1),
    .alu_data1_o(alu_a), .alu_data2_o(alu_b),
    .alu_select_o(alu_s), .alu_rotate_o(alu_r),
    .alu_result_i(alu_res), .alu_zero_i(alu_z),
    .alu_sign_i(alu_sg), .alu_sltu_i(alu_lt),
    .resp_valid_o(rv), .resp_ready_i(rr),
    .resp_id_o(rid), .resp_result_o(rres),
    .resp_zero_o(rz), .resp_sign_o(rsg),
    .resp_sltu_o(rlt)
  );

  function automatic logic [31:0] f_alu(
    input logic [2:0] s, input logic r,
    input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return r ? $unsigned($signed(a) >>> b[4:0])
                     : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Shared ALU stand-in
  always_comb begin
    alu_res = f_alu(alu_s, alu_r, alu_a, alu_b);
    alu_z   = (alu_res == 32'd0);
    alu_sg  = alu_res[31];
    alu_lt  = (alu_a < alu_b);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    v0 = 0; a0 = 0; b0 = 0; s0 = 0; o0 = 0;
    v1 = 0; a1 = 0; b1 = 0; s1 = 0; o1 = 0;
    rr = 0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    clr_in();
    rst = 1;
    v0 = 1; v1 = 1; a0 = 32'h1234;
    cyc();
    tests++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready got %b%b want 00", r0, r1);
    end
    tests++;
    if (rv !== 1'b0 || rid !== 1'b0) begin
      fails++;
      $display("FAIL rst_resp got v=%b id=%b want 0 0", rv, rid);
    end
    tests++;
    if ({rres, rz, rsg, rlt} !== 35'd0) begin
      fails++;
      $display("FAIL rst_res got %h %b%b%b want 0", rres, rz, rsg, rlt);
    end
    tests++;
    if ({alu_a, alu_b, alu_s, alu_r} !== 68'd0) begin
      fails++;
      $display("FAIL rst_alu got %h %h %0d %b want 0",
               alu_a, alu_b, alu_s, alu_r);
    end
    clr_in();
    cyc();
    rst = 0;
  endtask

  task automatic test_add();
    do_reset();
    rr = 1;
    v0 = 1; s0 = 3'd0; a0 = 5; b0 = 7;
    #1;
    tests++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      fails++;
      $display("FAIL add_ready got %b%b want 10", r0, r1);
    end
    cyc();
    v0 = 0;
    #1;
    tests++;
    if (rv !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      fails++;
      $display("FAIL add_exec got v=%b a=%h b=%h want 0 5 7",
               rv, alu_a, alu_b);
    end
    cyc();
    tests++;
    if (rv !== 1 || rres !== 32'd12 || rid !== 0 || rz !== 0) begin
      fails++;
      $display("FAIL add_resp got v=%b r=%h id=%b z=%b want 1 c 0 0",
               rv, rres, rid, rz);
    end
    cyc();
    tests++;
    if (rv !== 1'b0) begin
      fails++;
      $display("FAIL add_drop got v=%b want 0", rv);
    end
  endtask

  task automatic test_contention();
    int k;
    int last_t;
    logic [31:0] want;
    do_reset();
    rr = 1;
    v0 = 1; s0 = 3'd6; a0 = 32'hF0; b0 = 32'h0F;
    v1 = 1; s1 = 3'd7; a1 = 32'hFF; b1 = 32'h0F;
    k = 0;
    last_t = 0;
    for (int t = 0; t < 40 && k < 4; t++) begin
      #1;
      tests++;
      if (r0 === 1'b1 && r1 === 1'b1) begin
        fails++;
        $display("FAIL cont_onehot got 11 want <=1 high");
      end
      if (rv === 1'b1) begin
        want = (k % 2 == 0) ? 32'hFF : 32'h0F;
        tests++;
        if (rid !== k[0] || rres !== want) begin
          fails++;
          $display("FAIL cont_resp%0d got id=%b r=%h want %b %h",
                   k, rid, rres, k[0], want);
        end
        tests++;
        if ((k == 0 && t != 2) || (k > 0 && t - last_t != 3)) begin
          fails++;
          $display("FAIL cont_gap%0d got t=%0d prev=%0d want 3 apart",
                   k, t, last_t);
        end
        last_t = t;
        k++;
      end
      cyc();
    end
    tests++;
    if (k != 4) begin
      fails++;
      $display("FAIL cont_timeout got %0d responses want 4", k);
    end
    clr_in();
    cyc();
  endtask

  task automatic test_slt();
    int t;
    do_reset();
    rr = 1;
    v1 = 1; s1 = 3'd2; a1 = 32'hFFFFFFFF; b1 = 32'd1;
    #1;
    tests++;
    if (r1 !== 1'b1) begin
      fails++;
      $display("FAIL slt_ready got %b want 1", r1);
    end
    cyc();
    v1 = 0;
    t = 0;
    while (rv !== 1'b1 && t < 10) begin
      cyc();
      t++;
    end
    tests++;
    if (rv !== 1 || rres !== 32'd1 || rlt !== 0 || rsg !== 0 ||
        rid !== 1 || rz !== 0) begin
      fails++;
      $display("FAIL slt_resp got v=%b r=%h lt=%b sg=%b id=%b z=%b want 1 1 0 0 1 0",
               rv, rres, rlt, rsg, rid, rz);
    end
    cyc();
  endtask

  task automatic test_stall();
    do_reset();
    v0 = 1; s0 = 3'd4; a0 = 32'hA5A5A5A5; b0 = 32'hA5A5A5A5;
    cyc();
    v0 = 1; v1 = 1; a0 = 32'h1; s1 = 3'd0;
    #1;
    tests++;
    if (r0 !== 0 || r1 !== 0) begin
      fails++;
      $display("FAIL stall_exec_ready got %b%b want 00", r0, r1);
    end
    cyc();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rv !== 1 || rres !== 0 || rz !== 1 || r0 !== 0 || r1 !== 0) begin
        fails++;
        $display("FAIL stall_hold%0d got v=%b r=%h z=%b rdy=%b%b want 1 0 1 00",
                 i, rv, rres, rz, r0, r1);
      end
      cyc();
    end
    rr = 1;
    #1;
    tests++;
    if (rv !== 1 || r0 !== 0 || r1 !== 0) begin
      fails++;
      $display("FAIL stall_take got v=%b rdy=%b%b want 1 00", rv, r0, r1);
    end
    cyc();
    tests++;
    if (rv !== 0 || r1 !== 1 || r0 !== 0) begin
      fails++;
      $display("FAIL stall_idle got v=%b rdy=%b%b want 0 01", rv, r0, r1);
    end
    clr_in();
    cyc();
  endtask

  task automatic test_reset_exec();
    int t;
    do_reset();
    rr = 1;
    v0 = 1; s0 = 3'd7; a0 = 32'h3; b0 = 32'h6;
    cyc();
    v0 = 0;
    rst = 1;
    cyc();
    rst = 0;
    tests++;
    if (rv !== 0 || alu_s !== 3'd0) begin
      fails++;
      $display("FAIL rexec_clear got v=%b sel=%0d want 0 0", rv, alu_s);
    end
    t = 0;
    for (int i = 0; i < 5; i++) begin
      if (rv === 1'b1) t++;
      cyc();
    end
    tests++;
    if (t != 0) begin
      fails++;
      $display("FAIL rexec_ghost got %0d resp cycles want 0", t);
    end
    v1 = 1; s1 = 3'd6; a1 = 32'd3; b1 = 32'd4;
    #1;
    tests++;
    if (r1 !== 1'b1) begin
      fails++;
      $display("FAIL rexec_ready got %b want 1", r1);
    end
    cyc();
    v1 = 0;
    t = 0;
    while (rv !== 1'b1 && t < 10) begin
      cyc();
      t++;
    end
    tests++;
    if (rv !== 1 || rres !== 32'd7 || rid !== 1) begin
      fails++;
      $display("FAIL rexec_new got v=%b r=%h id=%b want 1 7 1",
               rv, rres, rid);
    end
    cyc();
  endtask

  task automatic test_operand_change();
    int t;
    do_reset();
    rr = 1;
    v0 = 1; s0 = 3'd0; a0 = 32'd100; b0 = 32'd23;
    cyc();
    v0 = 0; a0 = 32'd999; b0 = 32'd1;
    t = 0;
    while (rv !== 1'b1 && t < 10) begin
      cyc();
      t++;
    end
    tests++;
    if (rv !== 1 || rres !== 32'd123) begin
      fails++;
      $display("FAIL opchg got v=%b r=%0d want 1 123", rv, rres);
    end
    cyc();
  endtask

  // Transaction-level model: one op outstanding, response visible
  // two cycles after accept until taken, ties go to the other side.
  task automatic test_random();
    bit          busy;
    bit          last;
    int          t_acc;
    bit          e_g0, e_g1, e_rv;
    logic [31:0] e_a, e_b, e_res;
    logic [2:0]  e_s;
    logic        e_r, e_id;
    int          served0, served1;
    do_reset();
    busy = 0; last = 1; t_acc = 0;
    e_a = 0; e_b = 0; e_s = 0; e_r = 0; e_id = 0;
    served0 = 0; served1 = 0;
    for (int c = 0; c < 600; c++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      a0 = $urandom; b0 = $urandom;
      a1 = $urandom; b1 = $urandom;
      s0 = 3'($urandom_range(0, 7));
      s1 = 3'($urandom_range(0, 7));
      o0 = 1'($urandom_range(0, 1));
      o1 = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 9) < 6);
      #1;
      e_g0 = 0; e_g1 = 0;
      if (!busy) begin
        if (v0 && v1) begin
          e_g1 = !last;
          e_g0 = last;
        end else begin
          e_g0 = v0;
          e_g1 = v1;
        end
      end
      e_rv = busy && (c >= t_acc + 2);
      tests++;
      if (r0 !== e_g0 || r1 !== e_g1) begin
        fails++;
        $display("FAIL rnd_ready c=%0d got %b%b want %b%b",
                 c, r0, r1, e_g0, e_g1);
      end
      tests++;
      if (rv !== e_rv) begin
        fails++;
        $display("FAIL rnd_valid c=%0d got %b want %b", c, rv, e_rv);
      end
      if (busy) begin
        tests++;
        if (alu_a !== e_a || alu_b !== e_b ||
            alu_s !== e_s || alu_r !== e_r) begin
          fails++;
          $display("FAIL rnd_alu c=%0d got %h %h %0d %b want %h %h %0d %b",
                   c, alu_a, alu_b, alu_s, alu_r, e_a, e_b, e_s, e_r);
        end
      end
      if (e_rv) begin
        e_res = f_alu(e_s, e_r, e_a, e_b);
        tests++;
        if (rres !== e_res || rid !== e_id || rz !== (e_res == 0) ||
            rsg !== e_res[31] || rlt !== (e_a < e_b)) begin
          fails++;
          $display("FAIL rnd_resp c=%0d got %h id=%b %b%b%b want %h id=%b %b%b%b",
                   c, rres, rid, rz, rsg, rlt, e_res, e_id,
                   e_res == 0, e_res[31], e_a < e_b);
        end
      end
      if (e_rv && rr) begin
        busy = 0;
      end else if ((e_g0 && v0) || (e_g1 && v1)) begin
        busy = 1;
        t_acc = c;
        e_id = e_g1;
        last = e_g1;
        e_a = e_g1 ? a1 : a0;
        e_b = e_g1 ? b1 : b0;
        e_s = e_g1 ? s1 : s0;
        e_r = e_g1 ? o1 : o0;
        if (e_g1) served1++;
        else served0++;
      end
      cyc();
    end
    tests++;
    if (served0 == 0 || served1 == 0) begin
      fails++;
      $display("FAIL rnd_starve got %0d/%0d grants want both >0",
               served0, served1);
    end
    clr_in();
    rr = 1;
    repeat (4) cyc();
  endtask

  initial begin
    clr_in();
    rst = 1;
    test_reset();
    test_add();
    test_contention();
    test_slt();
    test_stall();
    test_reset_exec();
    test_operand_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, 0, requester that wins the first simultaneous request after reset (0 or 1).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 REQn_VALID  input  1  requester n (n=0,1) presents an operation.
REQ-006 REQn_READY  output  1  arbiter accepts requester n's operation this cycle.
REQ-007 REQn_DATA1, REQn_DATA2  input  32 each  operands.
REQ-008 REQn_SELECT  input  3  ALU function code (0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND).
REQ-009 REQn_ROTATE  input  1  SRL/SRA qualifier for SELECT=5.
REQ-010 ALU_DATA1, ALU_DATA2  output  32 each  operands driven to the shared ALU.
REQ-011 ALU_SELECT  output  3; ALU_ROTATE  output  1  function driven to the ALU.
REQ-012 ALU_RESULT  input  32; ALU_ZERO, ALU_SIGN, ALU_SLTU  input  1 each  combinational ALU outputs and flags.
REQ-013 RESP_VALID  output  1  response available.
REQ-014 RESP_READY  input  1  consumer takes response.
REQ-015 RESP_ID  output  1  requester that owns the response.
REQ-016 RESP_RESULT  output  32; RESP_ZERO, RESP_SIGN, RESP_SLTU  output  1 each  registered copies of ALU outputs.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; exactly one op in flight.
REQ-018 Grant (IDLE only): one requester valid -> that one; both valid -> requester != last-served pointer; neither -> no grant.
REQ-019 REQn_READY = 1 only in IDLE and only for the granted requester; at most one READY high per cycle; never high in EXEC/RESP.
REQ-020 Accept = REQn_VALID & REQn_READY; on accept, DATA1/DATA2/SELECT/ROTATE and ID latched into operation registers, last-served pointer := n, state -> EXEC.
REQ-021 ALU_* outputs always driven from operation registers; stable from accept until next accept.
REQ-022 EXEC lasts exactly one cycle; at its end ALU_RESULT/ALU_ZERO/ALU_SIGN/ALU_SLTU and latched ID captured into RESP_* registers; state -> RESP.
REQ-023 Latency: accept at cycle N -> RESP_VALID high from cycle N+2.
REQ-024 RESP: RESP_VALID=1; all RESP_* held stable until RESP_VALID & RESP_READY; then state -> IDLE, RESP_VALID=0 next cycle.
REQ-025 Min issue interval 3 cycles; no accept in the cycle a response is consumed.
REQ-026 RESP_READY ignored outside RESP.
REQ-027 Requester inputs changed after accept do not affect the in-flight result.
REQ-028 VALID deasserted before accept: no transaction, pointer unchanged.
REQ-029 Back-to-back contention with both valid continuously: grants alternate 0,1,0,1...; no starvation.

Reset
REQ-030 RESET high at edge: state=IDLE, RESP_VALID=0, RESP_ID=0, RESP_RESULT=0, RESP flags=0, operation registers=0 (ALU_SELECT=0, ALU_ROTATE=0, ALU_DATA*=0).
REQ-031 Last-served pointer reset to ~PRIO_INIT so PRIO_INIT wins first tie.
REQ-032 RESET during EXEC or RESP aborts the op; no response is ever produced for it.
REQ-033 READY outputs 0 while RESET high.

Verification
REQ-034 Reset; REQ0 ADD 5,7 accepted cycle N, RESP_READY=1 -> cycle N+2 RESP_VALID=1, RESP_RESULT=12, RESP_ID=0, ZERO=0.
REQ-035 PRIO_INIT=0, both valid continuously (REQ0 OR 0xF0,0x0F; REQ1 AND 0xFF,0x0F) -> responses ID 0 (0xFF), 1 (0x0F), 0, 1 in order, each 3 cycles apart.
REQ-036 REQ1 SLT 0xFFFFFFFF,1 -> RESP_RESULT=1, RESP_SLTU=0, RESP_SIGN=0, RESP_ID=1.
REQ-037 REQ0 XOR 0xA5A5A5A5,0xA5A5A5A5 with RESP_READY=0 five cycles -> RESP_VALID and RESULT=0, ZERO=1 held; both READY=0 throughout; consumed on sixth cycle, IDLE next.
REQ-038 RESET asserted in EXEC cycle -> next cycle RESP_VALID=0, ALU_SELECT=0, no response appears; new request then accepted normally.
REQ-039 After accept, change REQ0_DATA1 during EXEC -> result reflects originally accepted operands.
